// File: rtl/ram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared widths, FSM state encodings, the captured-access payload and a
// small alignment helper for the instruction/data RAM arbiter.
// ----------------------------------------------------------------------------
package ram_arbiter_pkg;

   // Bus widths
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;

   // Byte-select value that marks a full-word access
   localparam logic [SEL_W-1:0] SEL_WORD = 4'b1111;

   // Arbiter FSM state encodings
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INST = 2'd1,
      ST_DATA = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   // Identity of the most recently granted requester
   typedef enum logic {
      GR_INST = 1'b0,
      GR_DATA = 1'b1
   } grant_e;

   // Access parameters latched at grant time; RAM outputs come only from here
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [SEL_W-1:0]  sel;
      logic              write;
   } access_t;

   // A word access must sit on a 4-byte boundary; narrower accesses are free
   function automatic logic is_misaligned(input logic [SEL_W-1:0] sel,
                                          input logic [1:0]       addr_lo);
      return (sel == SEL_WORD) && (addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the instruction port, data port and RAM port of the arbiter.
//   slave  : arbiter view (takes requests, drives acks and the RAM strobe)
//   master : requester/RAM view (drives requests and RAM responses)
// ----------------------------------------------------------------------------
interface ram_arbiter_if;
   import ram_arbiter_pkg::*;

   // Instruction-fetch port
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_ack;
   logic [DATA_W-1:0] inst_rdata;

   // Data load/store port
   logic              data_req;
   logic              data_write;
   logic [SEL_W-1:0]  data_sel;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic              data_ack;
   logic [DATA_W-1:0] data_rdata;
   logic              data_addr_err;

   // RAM port
   logic              ram_en;
   logic [SEL_W-1:0]  ram_write_en;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_write_data;
   logic [DATA_W-1:0] ram_read_data;
   logic              ram_ready;

   // Pipeline stall request
   logic              stall_req;

   modport slave (
      input  inst_req, inst_addr,
      input  data_req, data_write, data_sel, data_addr, data_wdata,
      input  ram_read_data, ram_ready,
      output inst_ack, inst_rdata,
      output data_ack, data_rdata, data_addr_err,
      output ram_en, ram_write_en, ram_addr, ram_write_data,
      output stall_req
   );

   modport master (
      output inst_req, inst_addr,
      output data_req, data_write, data_sel, data_addr, data_wdata,
      output ram_read_data, ram_ready,
      input  inst_ack, inst_rdata,
      input  data_ack, data_rdata, data_addr_err,
      input  ram_en, ram_write_en, ram_addr, ram_write_data,
      input  stall_req
   );

endinterface

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
// Shares one single-ported RAM between an instruction-fetch port and a
// data load/store port. One access at a time; the RAM is driven only from
// values latched at grant. Misaligned word accesses are answered with an
// error ack without touching the RAM.
//
// Parameters
//   DATA_FIRST : 1 = data always wins a tie, 0 = ties alternate
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_arbiter_if.slave (request ports, RAM port, stall_req)
// ----------------------------------------------------------------------------
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter bit DATA_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   ram_arbiter_if.slave bus
);

   state_e            r_state;
   state_e            w_state_nxt;
   grant_e            r_last;
   access_t           r_acc;
   access_t           w_acc_nxt;

   logic              w_inst_pend;
   logic              w_data_pend;
   logic              w_grant_inst;
   logic              w_grant_data;
   logic              w_misaligned;
   logic              w_inst_done;
   logic              w_data_done;
   logic [SEL_W-1:0]  w_ram_we_nxt;

   logic              r_inst_ack;
   logic              r_data_ack;
   logic              r_addr_err;
   logic              r_ram_en;
   logic [SEL_W-1:0]  r_ram_we;
   logic [DATA_W-1:0] r_inst_rdata;
   logic [DATA_W-1:0] r_data_rdata;

   assign w_misaligned = is_misaligned(bus.data_sel, bus.data_addr[1:0]);
   assign w_inst_done  = (r_state == ST_INST) && bus.ram_ready;
   assign w_data_done  = (r_state == ST_DATA) && bus.ram_ready;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Arbitration, next state and next RAM-side values
   always_comb begin
      w_state_nxt  = r_state;
      w_grant_inst = 1'b0;
      w_grant_data = 1'b0;
      w_acc_nxt    = r_acc;
      w_ram_we_nxt = '0;
      // A requester whose ack is high this cycle is finished; its req
      // still being high must not start a second service.
      w_inst_pend  = bus.inst_req & ~r_inst_ack;
      w_data_pend  = bus.data_req & ~r_data_ack;

      case (r_state)
         ST_IDLE: begin
            if (w_inst_pend && w_data_pend) begin
               if (DATA_FIRST || (r_last == GR_INST)) begin
                  w_grant_data = 1'b1;
               end else begin
                  w_grant_inst = 1'b1;
               end
            end else if (w_data_pend) begin
               w_grant_data = 1'b1;
            end else if (w_inst_pend) begin
               w_grant_inst = 1'b1;
            end

            if (w_grant_data) begin
               w_state_nxt = w_misaligned ? ST_ERR : ST_DATA;
            end else if (w_grant_inst) begin
               w_state_nxt = ST_INST;
            end
         end
         ST_INST, ST_DATA: begin
            if (bus.ram_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ERR: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_grant_inst) begin
         w_acc_nxt = '{addr: bus.inst_addr, wdata: '0, sel: '0, write: 1'b0};
      end else if (w_grant_data) begin
         w_acc_nxt = '{addr:  bus.data_addr,
                       wdata: bus.data_wdata,
                       sel:   bus.data_sel,
                       write: bus.data_write};
      end

      if ((w_state_nxt == ST_DATA) && w_acc_nxt.write) begin
         w_ram_we_nxt = w_acc_nxt.sel;
      end
   end

   // Latched access, RAM strobes, acks and read-data holding registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc        <= '0;
         r_last       <= GR_INST;
         r_ram_en     <= 1'b0;
         r_ram_we     <= '0;
         r_inst_ack   <= 1'b0;
         r_data_ack   <= 1'b0;
         r_addr_err   <= 1'b0;
         r_inst_rdata <= '0;
         r_data_rdata <= '0;
      end else begin
         r_acc      <= w_acc_nxt;
         r_ram_en   <= (w_state_nxt == ST_INST) || (w_state_nxt == ST_DATA);
         r_ram_we   <= w_ram_we_nxt;
         r_inst_ack <= w_inst_done;
         r_data_ack <= w_data_done || (r_state == ST_ERR);
         r_addr_err <= (r_state == ST_ERR);

         if (w_grant_inst) begin
            r_last <= GR_INST;
         end else if (w_grant_data) begin
            r_last <= GR_DATA;
         end

         if (w_inst_done) begin
            r_inst_rdata <= bus.ram_read_data;
         end
         if (w_data_done) begin
            r_data_rdata <= bus.ram_read_data;
         end
      end
   end

   assign bus.inst_ack       = r_inst_ack;
   assign bus.inst_rdata     = r_inst_rdata;
   assign bus.data_ack       = r_data_ack;
   assign bus.data_rdata     = r_data_rdata;
   assign bus.data_addr_err  = r_addr_err;
   assign bus.ram_en         = r_ram_en;
   assign bus.ram_write_en   = r_ram_we;
   assign bus.ram_addr       = r_acc.addr;
   assign bus.ram_write_data = r_acc.wdata;

   // Stall while either requester is waiting; drops in its own ack cycle
   assign bus.stall_req = (bus.inst_req & ~r_inst_ack) |
                          (bus.data_req & ~r_data_ack);

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
// Two arbiters side by side: dut_a with fixed data priority, dut_b with
// alternating priority. dut_b mirrors dut_a's inputs unless b_own selects
// its own request lines. Directed table, corner-case sequences and a
// randomized run against a behavioural model of dut_a.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;
   import ram_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ram_arbiter_if bus_a ();
   ram_arbiter_if bus_b ();

   ram_arbiter #(.DATA_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   ram_arbiter #(.DATA_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   logic b_own;
   logic b_inst_req;
   logic b_data_req;

   always_comb begin
      bus_b.inst_req      = b_own ? b_inst_req : bus_a.inst_req;
      bus_b.data_req      = b_own ? b_data_req : bus_a.data_req;
      bus_b.inst_addr     = bus_a.inst_addr;
      bus_b.data_write    = bus_a.data_write;
      bus_b.data_sel      = bus_a.data_sel;
      bus_b.data_addr     = bus_a.data_addr;
      bus_b.data_wdata    = bus_a.data_wdata;
      bus_b.ram_read_data = bus_a.ram_read_data;
      bus_b.ram_ready     = bus_a.ram_ready;
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      bus_a.inst_req      = 1'b0;
      bus_a.inst_addr     = '0;
      bus_a.data_req      = 1'b0;
      bus_a.data_write    = 1'b0;
      bus_a.data_sel      = 4'b0000;
      bus_a.data_addr     = '0;
      bus_a.data_wdata    = '0;
      bus_a.ram_read_data = '0;
      bus_a.ram_ready     = 1'b1;
      b_own      = 1'b0;
      b_inst_req = 1'b0;
      b_data_req = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic data_load(input logic [31:0] addr);
      bus_a.data_req   = 1'b1;
      bus_a.data_write = 1'b0;
      bus_a.data_sel   = 4'b1111;
      bus_a.data_addr  = addr;
   endtask

   // ---------------- directed single-transaction table ----------------
   typedef struct {
      string       name;
      bit          is_data;
      bit          wr;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] word;
      bit          exp_en;
      logic [3:0]  exp_we;
      bit          exp_err;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   function automatic vec_t mk(input string n, input bit d, input bit w, input logic [3:0] s,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] wo,
                               input bit en, input logic [3:0] we, input bit er);
      vec_t v;
      v.name = n; v.is_data = d; v.wr = w; v.sel = s; v.addr = a; v.wdata = wd;
      v.word = wo; v.exp_en = en; v.exp_we = we; v.exp_err = er;
      return v;
   endfunction

   // ---------------- behavioural model of dut_a ----------------
   logic [31:0] mem   [256];
   logic [31:0] m_mem [256];
   int          m_owner;  // 0 none, 1 fetch, 2 data access, 3 misaligned
   bit          m_last_data;
   logic [31:0] m_addr, m_wdata, m_inst_rdata, m_data_rdata;
   logic [3:0]  m_sel, m_we;
   bit          m_wr, m_inst_ack, m_data_ack, m_err, m_ram_en;

   task automatic model_reset();
      m_owner = 0; m_last_data = 1'b0;
      m_addr = '0; m_wdata = '0; m_sel = '0; m_wr = 1'b0; m_we = '0;
      m_inst_ack = 1'b0; m_data_ack = 1'b0; m_err = 1'b0; m_ram_en = 1'b0;
      m_inst_rdata = '0; m_data_rdata = '0;
   endtask

   // Advance the model by one clock using the inputs currently driven
   task automatic model_step(input bit df);
      bit ia, da, pi, pd, take_data;
      int nxt;
      ia = (m_owner == 1) && bus_a.ram_ready;
      da = ((m_owner == 2) && bus_a.ram_ready) || (m_owner == 3);
      pi = bus_a.inst_req && !m_inst_ack;
      pd = bus_a.data_req && !m_data_ack;
      m_err = (m_owner == 3);
      if (ia) m_inst_rdata = m_mem[m_addr[9:2]];
      if ((m_owner == 2) && bus_a.ram_ready) begin
         m_data_rdata = m_mem[m_addr[9:2]];
         if (m_wr)
            for (int b = 0; b < 4; b++)
               if (m_sel[b]) m_mem[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
      end
      nxt = m_owner;
      if (m_owner == 0) begin
         take_data = pd && (!pi || df || !m_last_data);
         if (take_data) begin
            m_addr = bus_a.data_addr; m_wdata = bus_a.data_wdata;
            m_sel = bus_a.data_sel; m_wr = bus_a.data_write; m_last_data = 1'b1;
            nxt = ((m_sel == 4'hF) && (m_addr[1:0] != 2'b00)) ? 3 : 2;
         end else if (pi) begin
            m_addr = bus_a.inst_addr; m_wdata = '0; m_sel = '0; m_wr = 1'b0;
            m_last_data = 1'b0; nxt = 1;
         end
      end else if ((m_owner == 3) || bus_a.ram_ready) begin
         nxt = 0;
      end
      m_inst_ack = ia;
      m_data_ack = da;
      m_owner    = nxt;
      m_ram_en   = (nxt == 1) || (nxt == 2);
      m_we       = ((nxt == 2) && m_wr) ? m_sel : 4'b0000;
   endtask

   task automatic new_data_txn();
      logic [3:0] s;
      logic [31:0] a;
      case ($urandom_range(0, 5))
         0: s = 4'b0001;
         1: s = 4'b0010;
         2: s = 4'b0100;
         3: s = 4'b1000;
         4: s = 4'b0011;
         default: s = 4'b1111;
      endcase
      a = 32'($urandom_range(0, 1023));
      if ((s == 4'b1111) && ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
      bus_a.data_req   = 1'b1;
      bus_a.data_write = 1'($urandom_range(0, 1));
      bus_a.data_sel   = s;
      bus_a.data_addr  = a;
      bus_a.data_wdata = $urandom();
   endtask

   task automatic new_inst_txn();
      bus_a.inst_req  = 1'b1;
      bus_a.inst_addr = 32'($urandom_range(0, 255)) << 2;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);

      // Reset state, observed while reset is held
      chk1 ("rst_ram_en",     bus_a.ram_en, 1'b0);
      chk32("rst_ram_we",     32'(bus_a.ram_write_en), 32'h0);
      chk1 ("rst_inst_ack",   bus_a.inst_ack, 1'b0);
      chk1 ("rst_data_ack",   bus_a.data_ack, 1'b0);
      chk1 ("rst_addr_err",   bus_a.data_addr_err, 1'b0);
      chk32("rst_ram_addr",   bus_a.ram_addr, 32'h0);
      chk32("rst_inst_rdata", bus_a.inst_rdata, 32'h0);
      chk32("rst_data_rdata", bus_a.data_rdata, 32'h0);
      chk1 ("rst_b_ram_en",   bus_b.ram_en, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---------------- table ----------------
      vecs[0] = mk("fetch_100",    0, 0, 4'h0, 32'h100, 32'h0,        32'h11223344, 1, 4'h0, 0);
      vecs[1] = mk("st_byte_203",  1, 1, 4'h1, 32'h203, 32'hAABBCCDD, 32'h0,        1, 4'h1, 0);
      vecs[2] = mk("ld_word_202",  1, 0, 4'hF, 32'h202, 32'h0,        32'h99999999, 0, 4'h0, 1);
      vecs[3] = mk("ld_word_204",  1, 0, 4'hF, 32'h204, 32'h0,        32'hCAFEF00D, 1, 4'h0, 0);
      vecs[4] = mk("st_word_208",  1, 1, 4'hF, 32'h208, 32'h01020304, 32'h0,        1, 4'hF, 0);
      vecs[5] = mk("st_half_20a",  1, 1, 4'h3, 32'h20A, 32'h5566AABB, 32'h0,        1, 4'h3, 0);
      vecs[6] = mk("st_word_209",  1, 1, 4'hF, 32'h209, 32'hDEADBEEF, 32'h0,        0, 4'h0, 1);
      vecs[7] = mk("ld_byte_301",  1, 0, 4'h1, 32'h301, 32'h0,        32'h5A5AA5A5, 1, 4'h0, 0);

      for (int i = 0; i < NV; i++) begin
         v = vecs[i];
         bus_a.ram_ready     = 1'b1;
         bus_a.ram_read_data = v.word;
         if (v.is_data) begin
            bus_a.data_req   = 1'b1;
            bus_a.data_write = v.wr;
            bus_a.data_sel   = v.sel;
            bus_a.data_addr  = v.addr;
            bus_a.data_wdata = v.wdata;
         end else begin
            bus_a.inst_req  = 1'b1;
            bus_a.inst_addr = v.addr;
         end
         #1 chk1({v.name, "_stall0"}, bus_a.stall_req, 1'b1);
         @(negedge clk);
         chk1 ({v.name, "_ram_en"}, bus_a.ram_en, v.exp_en);
         chk32({v.name, "_ram_we"}, 32'(bus_a.ram_write_en), 32'(v.exp_we));
         if (v.exp_en) chk32({v.name, "_ram_addr"}, bus_a.ram_addr, v.addr);
         if (v.exp_we != 4'h0) chk32({v.name, "_ram_wdata"}, bus_a.ram_write_data, v.wdata);
         chk1({v.name, "_ack_early"}, v.is_data ? bus_a.data_ack : bus_a.inst_ack, 1'b0);
         @(negedge clk);
         if (v.is_data) begin
            chk1({v.name, "_data_ack"},   bus_a.data_ack, 1'b1);
            chk1({v.name, "_b_data_ack"}, bus_b.data_ack, 1'b1);
            chk1({v.name, "_addr_err"},   bus_a.data_addr_err, v.exp_err);
            if (!v.wr && !v.exp_err) chk32({v.name, "_data_rdata"}, bus_a.data_rdata, v.word);
         end else begin
            chk1 ({v.name, "_inst_ack"},   bus_a.inst_ack, 1'b1);
            chk1 ({v.name, "_b_inst_ack"}, bus_b.inst_ack, 1'b1);
            chk32({v.name, "_inst_rdata"}, bus_a.inst_rdata, v.word);
         end
         chk1({v.name, "_ram_en_done"}, bus_a.ram_en, 1'b0);
         drive_idle();
         @(negedge clk);
         chk1({v.name, "_inst_ack_pulse"}, bus_a.inst_ack, 1'b0);
         chk1({v.name, "_data_ack_pulse"}, bus_a.data_ack, 1'b0);
      end

      // ---------------- three wait states, then read-data hold ----------------
      bus_a.ram_ready = 1'b0;
      data_load(32'h40);
      #1 chk1("wait_stall_c0", bus_a.stall_req, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk1("wait_ram_en", bus_a.ram_en, 1'b1);
         chk1("wait_stall",  bus_a.stall_req, 1'b1);
         chk1("wait_no_ack", bus_a.data_ack, 1'b0);
         if (k == 4) begin
            bus_a.ram_ready     = 1'b1;
            bus_a.ram_read_data = 32'h0BADBEEF;
         end
      end
      @(negedge clk);
      chk1 ("wait_ack_c5",  bus_a.data_ack, 1'b1);
      chk32("wait_rdata",   bus_a.data_rdata, 32'h0BADBEEF);
      chk1 ("wait_stall_ack", bus_a.stall_req, 1'b0);
      drive_idle();
      bus_a.ram_read_data = 32'h12345678;
      repeat (3) @(negedge clk);
      chk32("hold_data_rdata", bus_a.data_rdata, 32'h0BADBEEF);
      chk1 ("hold_no_ack",     bus_a.data_ack, 1'b0);

      // ---------------- priority: fixed vs alternating ----------------
      apply_reset();
      bus_a.inst_req = 1'b1; bus_a.inst_addr = 32'h10;
      data_load(32'h20);
      @(negedge clk);
      chk32("prio1_a_addr", bus_a.ram_addr, 32'h20);
      chk32("prio1_b_addr", bus_b.ram_addr, 32'h20);
      @(negedge clk);
      chk1("prio1_a_dack", bus_a.data_ack, 1'b1);
      chk1("prio1_b_dack", bus_b.data_ack, 1'b1);
      bus_a.data_req = 1'b0;
      @(negedge clk);
      chk1 ("prio2_a_en",   bus_a.ram_en, 1'b1);
      chk32("prio2_a_addr", bus_a.ram_addr, 32'h10);
      chk32("prio2_b_addr", bus_b.ram_addr, 32'h10);
      @(negedge clk);
      chk1("prio2_a_iack", bus_a.inst_ack, 1'b1);
      chk1("prio2_b_iack", bus_b.inst_ack, 1'b1);
      bus_a.inst_req = 1'b0;
      data_load(32'h24);
      repeat (2) @(negedge clk);
      chk1("prio3_a_dack", bus_a.data_ack, 1'b1);
      bus_a.data_req = 1'b0;
      @(negedge clk);
      bus_a.inst_req = 1'b1; bus_a.inst_addr = 32'h14;
      data_load(32'h28);
      @(negedge clk);
      chk32("prio4_a_addr", bus_a.ram_addr, 32'h28);
      chk32("prio4_b_addr", bus_b.ram_addr, 32'h14);
      @(negedge clk);
      chk1("prio4_a_dack", bus_a.data_ack, 1'b1);
      chk1("prio4_a_iack", bus_a.inst_ack, 1'b0);
      chk1("prio4_b_iack", bus_b.inst_ack, 1'b1);
      chk1("prio4_b_dack", bus_b.data_ack, 1'b0);
      b_own = 1'b1; b_inst_req = 1'b0; b_data_req = 1'b1;
      bus_a.data_req = 1'b0;
      @(negedge clk);
      chk32("prio5_a_addr", bus_a.ram_addr, 32'h14);
      chk32("prio5_b_addr", bus_b.ram_addr, 32'h28);
      @(negedge clk);
      chk1("prio5_a_iack", bus_a.inst_ack, 1'b1);
      chk1("prio5_b_dack", bus_b.data_ack, 1'b1);
      drive_idle();
      @(negedge clk);

      // ---------------- reset during a data wait ----------------
      bus_a.ram_ready     = 1'b0;
      bus_a.ram_read_data = 32'h66666666;
      data_load(32'h80);
      @(negedge clk);
      chk1("rstmid_en_before", bus_a.ram_en, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk1 ("rstmid_en_now",   bus_a.ram_en, 1'b0);
      chk32("rstmid_addr",     bus_a.ram_addr, 32'h0);
      chk32("rstmid_drdata",   bus_a.data_rdata, 32'h0);
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk1("rstmid_no_ack", bus_a.data_ack, 1'b0);
         chk1("rstmid_idle",   bus_a.ram_en, 1'b0);
      end
      bus_a.ram_read_data = 32'h00000077;
      data_load(32'h84);
      repeat (2) @(negedge clk);
      chk1 ("rstmid_rereq_ack",   bus_a.data_ack, 1'b1);
      chk32("rstmid_rereq_rdata", bus_a.data_rdata, 32'h00000077);
      drive_idle();
      @(negedge clk);

      // ---------------- requester withdraws mid-access ----------------
      bus_a.ram_ready = 1'b0;
      bus_a.inst_req  = 1'b1;
      bus_a.inst_addr = 32'h44;
      @(negedge clk);
      chk1("drop_en", bus_a.ram_en, 1'b1);
      bus_a.inst_req = 1'b0;
      @(negedge clk);
      chk1("drop_still_en", bus_a.ram_en, 1'b1);
      bus_a.ram_ready     = 1'b1;
      bus_a.ram_read_data = 32'h44444444;
      @(negedge clk);
      chk1 ("drop_ack",   bus_a.inst_ack, 1'b1);
      chk32("drop_rdata", bus_a.inst_rdata, 32'h44444444);
      @(negedge clk);
      chk1("drop_ack_pulse", bus_a.inst_ack, 1'b0);

      // ---------------- randomized run against the model ----------------
      for (int i = 0; i < 256; i++) begin
         mem[i]   = $urandom();
         m_mem[i] = mem[i];
      end
      apply_reset();
      model_reset();
      for (int c = 0; c < 2000; c++) begin
         chk1 ("rnd_inst_ack",   bus_a.inst_ack, m_inst_ack);
         chk1 ("rnd_data_ack",   bus_a.data_ack, m_data_ack);
         chk1 ("rnd_addr_err",   bus_a.data_addr_err, m_err);
         chk1 ("rnd_ram_en",     bus_a.ram_en, m_ram_en);
         chk32("rnd_ram_we",     32'(bus_a.ram_write_en), 32'(m_we));
         chk32("rnd_inst_rdata", bus_a.inst_rdata, m_inst_rdata);
         chk32("rnd_data_rdata", bus_a.data_rdata, m_data_rdata);
         if (m_ram_en) chk32("rnd_ram_addr", bus_a.ram_addr, m_addr);
         if (m_we != 4'h0) chk32("rnd_ram_wdata", bus_a.ram_write_data, m_wdata);

         if (bus_a.inst_req && m_inst_ack) begin
            if ($urandom_range(0, 1) == 1) new_inst_txn(); else bus_a.inst_req = 1'b0;
         end else if (!bus_a.inst_req && ($urandom_range(0, 3) == 0)) begin
            new_inst_txn();
         end
         if (bus_a.data_req && m_data_ack) begin
            if ($urandom_range(0, 1) == 1) new_data_txn(); else bus_a.data_req = 1'b0;
         end else if (!bus_a.data_req && ($urandom_range(0, 3) == 0)) begin
            new_data_txn();
         end

         // RAM: read returns the pre-write word; write lands after the read
         bus_a.ram_ready     = ($urandom_range(0, 2) != 0);
         bus_a.ram_read_data = mem[bus_a.ram_addr[9:2]];
         if (bus_a.ram_en && bus_a.ram_ready)
            for (int b = 0; b < 4; b++)
               if (bus_a.ram_write_en[b])
                  mem[bus_a.ram_addr[9:2]][8*b +: 8] = bus_a.ram_write_data[8*b +: 8];

         #1 chk1("rnd_stall", bus_a.stall_req,
                 (bus_a.inst_req & ~m_inst_ack) | (bus_a.data_req & ~m_data_ack));
         model_step(1'b1);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: DATA_FIRST, 1, fixed data-over-instruction priority when 1; alternating priority on simultaneous requests when 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 inst_req  input  1  instruction-fetch read request; held high until inst_ack.
REQ-005 inst_addr  input  `ADDR_BUS  fetch address.
REQ-006 inst_ack  output  1  one-cycle pulse: fetch complete.
REQ-007 inst_rdata  output  `DATA_BUS  fetched word; valid while inst_ack=1.
REQ-008 data_req  input  1  data access request; held high until data_ack.
REQ-009 data_write  input  1  1=store, 0=load.
REQ-010 data_sel  input  `MEM_SEL_BUS  byte select (4'b0001 byte, 4'b1111 word).
REQ-011 data_addr / data_wdata  input  `ADDR_BUS / `DATA_BUS  access address / store data.
REQ-012 data_ack  output  1  one-cycle pulse: data access complete.
REQ-013 data_rdata  output  `DATA_BUS  raw RAM word for loads; valid while data_ack=1.
REQ-014 data_addr_err  output  1  valid with data_ack; word access with addr[1:0]!=0.
REQ-015 ram_en  output  1  RAM access strobe.
REQ-016 ram_write_en  output  `MEM_SEL_BUS  per-byte write enables.
REQ-017 ram_addr / ram_write_data  output  `ADDR_BUS / `DATA_BUS  to RAM.
REQ-018 ram_read_data  input  `DATA_BUS  from RAM.
REQ-019 ram_ready  input  1  RAM completes current access this cycle.
REQ-020 stall_req  output  1  pipeline stall request.

Function
REQ-021 FSM states SHALL be IDLE, INST, DATA, ERR.
REQ-022 IDLE: data_req only -> DATA (or ERR if misaligned); inst_req only -> INST; neither -> IDLE.
REQ-023 Simultaneous requests: DATA_FIRST=1 -> data wins; DATA_FIRST=0 -> winner opposite of last granted requester (initial last = INST, so data first).
REQ-024 On grant, address, wdata, sel, write flag SHALL be registered; RAM outputs driven only from registered values.
REQ-025 ram_en=1 exactly in INST and DATA; ram_write_en = registered sel when DATA and write, else 4'b0000.
REQ-026 INST/DATA hold until ram_ready=1; that edge captures ram_read_data into the requester's rdata register, pulses its ack next cycle, returns to IDLE.
REQ-027 Latency: request in IDLE at cycle 0, ram_ready at first bus cycle (1) -> ack at cycle 2; each extra wait cycle adds one.
REQ-028 New grant evaluated in the cycle ack is high only if the other requester is pending; acked requester's req ignored that cycle (no double service).
REQ-029 Misaligned word access (data_sel=4'b1111, data_addr[1:0]!=0): ERR for one cycle, no RAM access, then data_ack=1 with data_addr_err=1.
REQ-030 Requester dropping req mid-access: access SHALL complete, ack pulsed anyway.
REQ-031 stall_req = (inst_req & ~inst_ack) | (data_req & ~data_ack), combinational.
REQ-032 rdata outputs SHALL hold last captured value between acks.

Reset
REQ-033 rst low SHALL immediately force IDLE, ram_en=0, ram_write_en=0, acks=0, data_addr_err=0, all data/address registers 0, last-granted=INST.
REQ-034 Reset mid-access SHALL abort; no ack issued for the aborted access after release.

Structure
REQ-035 Widths come from the shared bus.v macros (`ADDR_BUS, `DATA_BUS, `MEM_SEL_BUS); FSM state encodings defined as constants there.
REQ-036 Single flat module; no sub-module.

Verification
REQ-037 inst_req, addr 0x100, ram_ready immediate -> ram_en cycle 1, inst_ack cycle 2, inst_rdata=RAM word.
REQ-038 Simultaneous inst_req/data_req, DATA_FIRST=1 -> data served first, inst next; DATA_FIRST=0 twice -> grants alternate.
REQ-039 Store sel 4'b0001 addr 0x203, wdata 0xAABBCCDD -> ram_write_en=4'b0001, ram_addr=0x203, one data_ack.
REQ-040 Word load addr 0x202 -> no ram_en, data_ack with data_addr_err=1 two cycles after request.
REQ-041 ram_ready delayed 3 cycles -> ram_en held 4 cycles, stall_req high throughout, ack cycle 5.
REQ-042 rst asserted during DATA wait -> ram_en low same cycle; after release no data_ack until re-request.
